cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 29 ++
 rtl/mem_wait_timer.sv | 24 ++
 rtl/cpu_sequencer.sv | 179 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state codes, opcodes and datapath select encodings shared by the sequencer.
package cpu_ctrl_pkg;
    typedef enum logic [3:0] {
        HALT, FETCH, DECODE, IND_RD, IND_WB, EXEC, EXEC2, INT_SAVE
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    typedef enum logic [2:0] {ac_none, ac_and_md, ac_add_md, ac_zero, ac_iot, ac_uc} ac_sel_t;
    typedef enum logic [2:0] {pc_none, pc_incr, pc_ma, pc_ma1, pc_one} pc_sel_t;
    typedef enum logic [1:0] {skip_none, skip_iot, skip_uc, skip_md_clear} skip_sel_t;
    typedef enum logic [2:0] {addr_none, addr_pc, addr_ea, addr_ma, addr_zero} addr_sel_t;
    typedef enum logic [2:0] {data_none, data_ac, data_pc1, data_md, data_pc} data_sel_t;
    typedef enum logic {iot_none, iot_en} iot_sel_t;
    typedef enum logic {ir_none, ir_data} ir_sel_t;
    typedef enum logic [1:0] {ma_none, ma_ea, ma_data, ma_data1} ma_sel_t;
    typedef enum logic [1:0] {md_none, md_data, md_data1} md_sel_t;

    function automatic logic is_operate(input logic [2:0] op);
        return op == OP_OPR || op == OP_IOT;
    endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles and flags when the limit is reached.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic mem_valid,
    input  logic state_chg,
    output logic timeout
);
    localparam int W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (mem_valid || state_chg) cnt <= '0;
        else if (busy && cnt != '1) cnt <= cnt + 1'b1;
    end

    // a completion arriving in the limit cycle still wins
    assign timeout = (MEM_TIMEOUT != 0) && !mem_valid && cnt == W'(MEM_TIMEOUT);
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: PDP-8 style major-state sequencer driving datapath selects and memory strobes.
module cpu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 15,
    parameter int AUTOINDEX_EN = 1,
    parameter int INT_EN       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       halt_req,
    input  logic       step,
    input  logic [2:0] opcode,
    input  logic       indirect,
    input  logic       autoindex,
    input  logic       int_req,
    input  logic       int_on,
    input  logic       mem_valid,
    output ac_sel_t    sel_ac,
    output pc_sel_t    sel_pc,
    output skip_sel_t  sel_skip,
    output addr_sel_t  sel_addr,
    output data_sel_t  sel_data,
    output iot_sel_t   sel_iot,
    output ir_sel_t    sel_ir,
    output ma_sel_t    sel_ma,
    output md_sel_t    sel_md,
    output logic       mem_read,
    output logic       mem_write,
    output logic       halted,
    output logic       int_ack,
    output logic       bus_error,
    output logic [3:0] state_o
);
    state_t state, state_nxt;
    logic   step_latch, eoi, timeout;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .busy     (mem_read | mem_write),
        .mem_valid(mem_valid),
        .state_chg(state_nxt != state),
        .timeout  (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HALT;
            bus_error  <= 1'b0;
            step_latch <= 1'b0;
        end else begin
            state <= state_nxt;
            if (timeout) bus_error <= 1'b1;
            else if (state == HALT && run) bus_error <= 1'b0;
            if (state == HALT && step) step_latch <= 1'b1;
            else if (state_nxt == HALT) step_latch <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_ac    = ac_none;
        sel_pc    = pc_none;
        sel_skip  = skip_none;
        sel_addr  = addr_none;
        sel_data  = data_none;
        sel_iot   = iot_none;
        sel_ir    = ir_none;
        sel_ma    = ma_none;
        sel_md    = md_none;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        int_ack   = 1'b0;
        eoi       = 1'b0;
        case (state)
            HALT: if (run || step) state_nxt = FETCH;
            FETCH: begin
                sel_addr = addr_pc;
                sel_ir   = ir_data;
                mem_read = 1'b1;
                if (mem_valid) state_nxt = DECODE;
            end
            DECODE: begin
                if (!is_operate(opcode) && !indirect) sel_ma = ma_ea;
                state_nxt = (!is_operate(opcode) && indirect) ? IND_RD : EXEC;
            end
            IND_RD: begin
                sel_addr = addr_ea;
                mem_read = 1'b1;
                sel_ma   = ma_data;
                if (mem_valid) state_nxt = EXEC;
                // auto-index: the incremented pointer becomes EA and is written back
                if (mem_valid && autoindex && AUTOINDEX_EN != 0) begin
                    sel_md    = md_data1;
                    sel_ma    = ma_data1;
                    state_nxt = IND_WB;
                end
            end
            IND_WB: begin
                sel_addr  = addr_ea;
                sel_data  = data_md;
                mem_write = 1'b1;
                if (mem_valid) state_nxt = EXEC;
            end
            EXEC: begin
                case (opcode)
                    OP_AND, OP_TAD, OP_ISZ: begin
                        sel_addr = addr_ma;
                        mem_read = 1'b1;
                        sel_md   = opcode == OP_ISZ ? md_data1 : md_data;
                    end
                    OP_DCA, OP_JMS: begin
                        sel_addr  = addr_ma;
                        sel_data  = opcode == OP_JMS ? data_pc1 : data_ac;
                        mem_write = 1'b1;
                    end
                    OP_JMP: begin
                        sel_pc = pc_ma;
                        eoi    = 1'b1;
                    end
                    default: begin
                        sel_ac   = opcode == OP_IOT ? ac_iot : ac_uc;
                        sel_pc   = pc_incr;
                        sel_skip = opcode == OP_IOT ? skip_iot : skip_uc;
                        sel_iot  = opcode == OP_IOT ? iot_en : iot_none;
                        eoi      = 1'b1;
                    end
                endcase
                if ((mem_read || mem_write) && mem_valid) state_nxt = EXEC2;
            end
            EXEC2: begin
                if (opcode == OP_ISZ) begin
                    sel_addr  = addr_ma;
                    sel_data  = data_md;
                    mem_write = 1'b1;
                    sel_pc    = mem_valid ? pc_incr : pc_none;
                    sel_skip  = mem_valid ? skip_md_clear : skip_none;
                    eoi       = mem_valid;
                end else begin
                    sel_pc = opcode == OP_JMS ? pc_ma1 : pc_incr;
                    sel_ac = opcode == OP_AND ? ac_and_md : opcode == OP_TAD ? ac_add_md :
                             opcode == OP_DCA ? ac_zero : ac_none;
                    eoi    = 1'b1;
                end
            end
            INT_SAVE: begin
                sel_addr  = addr_zero;
                sel_data  = data_pc;
                mem_write = 1'b1;
                if (mem_valid) begin
                    sel_pc    = pc_one;
                    int_ack   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = HALT;
        endcase
        if (eoi) state_nxt = (halt_req || step_latch) ? HALT :
                             (INT_EN != 0 && int_req && int_on) ? INT_SAVE : FETCH;
        // a timed-out access abandons the instruction without touching the datapath
        if (timeout) begin
            state_nxt = HALT;
            sel_ac    = ac_none;
            sel_pc    = pc_none;
            sel_skip  = skip_none;
            sel_addr  = addr_none;
            sel_data  = data_none;
            sel_iot   = iot_none;
            sel_ir    = ir_none;
            sel_ma    = ma_none;
            sel_md    = md_none;
        end
    end

    assign halted  = state == HALT;
    assign state_o = state;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed-step self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset, run, halt_req, step, indirect, autoindex, int_req, int_on, mem_valid;
    logic [2:0] opcode;
    ac_sel_t    sel_ac;
    pc_sel_t    sel_pc;
    skip_sel_t  sel_skip;
    addr_sel_t  sel_addr;
    data_sel_t  sel_data;
    iot_sel_t   sel_iot;
    ir_sel_t    sel_ir;
    ma_sel_t    sel_ma;
    md_sel_t    sel_md;
    logic       mem_read, mem_write, halted, int_ack, bus_error;
    logic [3:0] state_o;
    int         checks = 0, failures = 0, fetches, pcma;

    cpu_sequencer #(.MEM_TIMEOUT(4), .AUTOINDEX_EN(1), .INT_EN(1)) dut (
        .clk(clk), .reset(reset), .run(run), .halt_req(halt_req), .step(step),
        .opcode(opcode), .indirect(indirect), .autoindex(autoindex),
        .int_req(int_req), .int_on(int_on), .mem_valid(mem_valid),
        .sel_ac(sel_ac), .sel_pc(sel_pc), .sel_skip(sel_skip), .sel_addr(sel_addr),
        .sel_data(sel_data), .sel_iot(sel_iot), .sel_ir(sel_ir), .sel_ma(sel_ma),
        .sel_md(sel_md), .mem_read(mem_read), .mem_write(mem_write), .halted(halted),
        .int_ack(int_ack), .bus_error(bus_error), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; run = 0; halt_req = 0; step = 0; indirect = 0; autoindex = 0;
        int_req = 0; int_on = 0; mem_valid = 0; opcode = OP_TAD;
        #2;
        chk("rst_halted", halted, 1); chk("rst_state", state_o, 0); chk("rst_rd", mem_read, 0);
        chk("rst_wr", mem_write, 0); chk("rst_ack", int_ack, 0); chk("rst_berr", bus_error, 0);
        nxt; nxt; reset = 0; #2;
        chk("idle_state", state_o, HALT); chk("idle_halted", halted, 1);
        // TAD direct, two-cycle memory
        run = 1; nxt; run = 0; #2;
        chk("tad_fetch", state_o, FETCH); chk("tad_fetch_rd", mem_read, 1);
        chk("tad_fetch_addr", sel_addr, addr_pc); chk("tad_fetch_ir", sel_ir, ir_data);
        chk("tad_fetch_halted", halted, 0);
        nxt; mem_valid = 1; #2; chk("tad_fetch2", state_o, FETCH);
        nxt; mem_valid = 0; #2; chk("tad_decode", state_o, DECODE); chk("tad_ma_ea", sel_ma, ma_ea);
        nxt; #2;
        chk("tad_exec", state_o, EXEC); chk("tad_exec_rd", mem_read, 1);
        chk("tad_exec_addr", sel_addr, addr_ma); chk("tad_exec_md", sel_md, md_data);
        nxt; mem_valid = 1; #2; chk("tad_exec_wait", state_o, EXEC);
        nxt; mem_valid = 0; #2;
        chk("tad_exec2", state_o, EXEC2); chk("tad_add", sel_ac, ac_add_md);
        chk("tad_pc", sel_pc, pc_incr); chk("tad_exec2_rd", mem_read, 0);
        nxt; #2; chk("tad_refetch", state_o, FETCH);
        // TAD indirect with auto-index
        indirect = 1; autoindex = 1; mem_valid = 1; nxt; mem_valid = 0; #2;
        chk("ind_decode", state_o, DECODE); chk("ind_decode_ma", sel_ma, ma_none);
        nxt; #2;
        chk("ind_rd", state_o, IND_RD); chk("ind_rd_addr", sel_addr, addr_ea);
        chk("ind_rd_rd", mem_read, 1); chk("ind_rd_ma", sel_ma, ma_data); chk("ind_rd_md", sel_md, md_none);
        mem_valid = 1; #1;
        chk("ind_md1", sel_md, md_data1); chk("ind_ma1", sel_ma, ma_data1);
        nxt; mem_valid = 0; #2;
        chk("ind_wb", state_o, IND_WB); chk("ind_wb_wr", mem_write, 1); chk("ind_wb_rd", mem_read, 0);
        chk("ind_wb_addr", sel_addr, addr_ea); chk("ind_wb_data", sel_data, data_md);
        mem_valid = 1; nxt; #2; chk("ind_exec", state_o, EXEC);
        nxt; #2; chk("ind_exec2", state_o, EXEC2);
        // OPR with interrupt pending
        nxt; #2; chk("opr_fetch", state_o, FETCH);
        opcode = OP_OPR; indirect = 0; autoindex = 0;
        nxt; #2; chk("opr_decode", state_o, DECODE);
        nxt; #2;
        chk("opr_exec", state_o, EXEC); chk("opr_ac", sel_ac, ac_uc); chk("opr_pc", sel_pc, pc_incr);
        chk("opr_skip", sel_skip, skip_uc); chk("opr_rd", mem_read, 0); chk("opr_wr", mem_write, 0);
        int_req = 1; int_on = 1; mem_valid = 0; nxt; #2;
        chk("int_save", state_o, INT_SAVE); chk("int_addr", sel_addr, addr_zero);
        chk("int_data", sel_data, data_pc); chk("int_wr", mem_write, 1);
        chk("int_ack_wait", int_ack, 0); chk("int_pc_wait", sel_pc, pc_none);
        mem_valid = 1; #1;
        chk("int_ack", int_ack, 1); chk("int_pc_one", sel_pc, pc_one);
        nxt; int_req = 0; int_on = 0; #2;
        chk("int_fetch", state_o, FETCH); chk("int_ack_after", int_ack, 0);
        // JMP ending in HALT, then a single step
        opcode = OP_JMP; halt_req = 1;
        nxt; #2; chk("jmp_decode", state_o, DECODE);
        nxt; #2; chk("jmp_exec", state_o, EXEC); chk("jmp_pc", sel_pc, pc_ma);
        nxt; halt_req = 0; #2; chk("jmp_halt", state_o, HALT); chk("jmp_halted", halted, 1);
        step = 1; #2; chk("step_halt", state_o, HALT);
        nxt; step = 0; fetches = 0; pcma = 0;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (state_o == FETCH) fetches++;
            if (sel_pc == pc_ma) pcma++;
            nxt;
        end
        chk("step_fetches", 8'(fetches), 1); chk("step_pcma", 8'(pcma), 1);
        chk("step_halt_end", state_o, HALT);
        // memory timeout in FETCH
        run = 1; mem_valid = 0; nxt; run = 0;
        for (int i = 1; i <= 4; i++) begin
            #2; chk("to_fetch", state_o, FETCH); chk("to_rd", mem_read, 1);
            nxt;
        end
        #2;
        chk("to_limit_state", state_o, FETCH); chk("to_limit_addr", sel_addr, addr_none);
        chk("to_limit_ir", sel_ir, ir_none); chk("to_limit_berr", bus_error, 0);
        nxt; #2; chk("to_halt", state_o, HALT); chk("to_berr", bus_error, 1);
        nxt; #2; chk("to_berr_hold", bus_error, 1); chk("to_halt_hold", state_o, HALT);
        run = 1; nxt; run = 0; mem_valid = 1; #2;
        chk("to_run_fetch", state_o, FETCH); chk("to_berr_clr", bus_error, 0);
        // ISZ full sequence
        opcode = OP_ISZ;
        nxt; nxt; #2; chk("isz_exec", state_o, EXEC); chk("isz_md1", sel_md, md_data1); chk("isz_rd", mem_read, 1);
        nxt; mem_valid = 0; #2;
        chk("isz_exec2", state_o, EXEC2); chk("isz_wr", mem_write, 1); chk("isz_data", sel_data, data_md);
        chk("isz_addr", sel_addr, addr_ma); chk("isz_pc_wait", sel_pc, pc_none); chk("isz_skip_wait", sel_skip, skip_none);
        nxt; #2; chk("isz_hold", state_o, EXEC2);
        mem_valid = 1; #1; chk("isz_skip", sel_skip, skip_md_clear); chk("isz_pc", sel_pc, pc_incr);
        nxt; #2; chk("isz_refetch", state_o, FETCH);
        // ISZ interrupted by reset during its write
        nxt; nxt; nxt; mem_valid = 0; #2;
        chk("iszr_exec2", state_o, EXEC2); chk("iszr_wr", mem_write, 1);
        reset = 1; #1;
        chk("iszr_halted", halted, 1); chk("iszr_wr_off", mem_write, 0); chk("iszr_state", state_o, 0);
        nxt; reset = 0; #2;
        chk("iszr_after", state_o, 0); chk("iszr_after_halted", halted, 1); chk("iszr_berr", bus_error, 0);
        // run with halt_req: one DCA then HALT
        opcode = OP_DCA; halt_req = 1; run = 1; mem_valid = 1;
        nxt; run = 0; #2; chk("hr_fetch", state_o, FETCH);
        nxt; nxt; #2;
        chk("dca_exec", state_o, EXEC); chk("dca_wr", mem_write, 1); chk("dca_rd", mem_read, 0);
        chk("dca_data", sel_data, data_ac); chk("dca_addr", sel_addr, addr_ma);
        nxt; #2; chk("dca_exec2", state_o, EXEC2); chk("dca_ac", sel_ac, ac_zero); chk("dca_pc", sel_pc, pc_incr);
        nxt; #2; chk("hr_halt", state_o, HALT);
        halt_req = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
